// File: rtl/wb_port_arb.sv
// Write-back GPR port arbiter: shares the single GPR write port between
// LSU commits and a one-entry MDU result skid buffer with a forward-progress timer.
module wb_port_arb #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        LS_WB_reg_ls_valid,
    output logic        WB_LS_ls_ready,
    input  logic        LS_WB_reg_dest_wen,
    input  logic [4:0]  LS_WB_reg_rd,
    input  logic        LS_WB_reg_csr_ren,
    input  logic [63:0] LS_WB_reg_data,
    input  logic [63:0] csr_rdata,
    input  logic        mdu_wb_valid,
    output logic        mdu_wb_ready,
    input  logic [4:0]  mdu_wb_rd,
    input  logic [63:0] mdu_wb_data,
    input  logic        mdu_kill,
    output logic        gpr_wen,
    output logic [4:0]  gpr_rd,
    output logic [63:0] gpr_wdata,
    output logic        mdu_pend_valid,
    output logic [4:0]  mdu_pend_rd
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        EMPTY,
        PEND,
        FORCE
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    buf_rd_q, buf_rd_d;
    logic [63:0]   buf_data_q, buf_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ls_wr;

    assign WB_LS_ls_ready = (state_q != FORCE);
    assign mdu_wb_ready   = (state_q == EMPTY);
    assign mdu_pend_valid = (state_q != EMPTY);
    assign mdu_pend_rd    = buf_rd_q;

    assign ls_wr = LS_WB_reg_ls_valid & WB_LS_ls_ready
                 & LS_WB_reg_dest_wen & (LS_WB_reg_rd != 5'd0);

    // The LSU always has priority on the port; the buffer fills idle slots.
    always_comb begin
        gpr_wen   = 1'b0;
        gpr_rd    = 5'd0;
        gpr_wdata = 64'd0;
        if (ls_wr) begin
            gpr_wen   = 1'b1;
            gpr_rd    = LS_WB_reg_rd;
            gpr_wdata = LS_WB_reg_csr_ren ? csr_rdata : LS_WB_reg_data;
        end else if ((state_q != EMPTY) && !mdu_kill) begin
            gpr_wen   = 1'b1;
            gpr_rd    = buf_rd_q;
            gpr_wdata = buf_data_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        cnt_d      = cnt_q;
        if (mdu_kill) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (mdu_wb_valid && (mdu_wb_rd != 5'd0)) begin
                        buf_rd_d   = mdu_wb_rd;
                        buf_data_d = mdu_wb_data;
                        cnt_d      = '0;
                        state_d    = PEND;
                    end
                end
                PEND: begin
                    // A younger LSU write to the same rd makes the buffer stale.
                    if (!ls_wr || (LS_WB_reg_rd == buf_rd_q)) begin
                        state_d = EMPTY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = FORCE;
                        end
                    end
                end
                FORCE: begin
                    state_d = EMPTY;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = EMPTY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            buf_rd_q   <= 5'd0;
            buf_data_q <= 64'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
